// File: rtl/audio_sram_pkg.sv
// Shared widths, FSM state encoding and the PCM byte-swap helper for the
// audio SRAM streamer.
package audio_sram_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        AUD_RD  = 2'd1,
        HOST_RD = 2'd2
    } state_t;

    // Little-endian PCM words arrive with their bytes reversed.
    function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Prefetch FIFO for audio samples. Flush wins over push/pop; the head word
// is presented combinationally on dout.
module sample_fifo
    import audio_sram_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/audio_sram_streamer.sv
// Read-only SRAM sequencer: streams an audio address window into a prefetch
// FIFO for the codec and interleaves single-word host reads. Audio has
// priority while the FIFO is under half full.
module audio_sram_streamer
    import audio_sram_pkg::*;
#(
    parameter int READ_WAIT  = 2,
    parameter int FIFO_DEPTH = 8,
    parameter bit SWAP_BYTES = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        loop,
    input  logic [19:0] start_addr,
    input  logic [19:0] end_addr,
    input  logic        sample_req,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        underrun,
    output logic        done,
    input  logic        host_req,
    input  logic [19:0] host_addr,
    output logic [15:0] host_rdata,
    output logic        host_ack,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    input  logic [15:0] SRAM_DQ
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    state_t              state_q, state_d;
    logic [WW-1:0]       wait_q, wait_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic                play_q;
    logic                finished_q, finished_d;
    logic                discard_q, discard_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                host_ack_q, host_ack_d;
    logic [DATA_W-1:0]   sample_out_q, sample_out_d;
    logic                sample_valid_q, sample_valid_d;
    logic                underrun_q, underrun_d;
    logic                done_q, done_d;

    logic                fifo_push, fifo_pop, fifo_flush;
    logic [DATA_W-1:0]   fifo_din, fifo_dout;
    logic [CW-1:0]       fifo_count;
    logic                fifo_empty, fifo_full;

    logic play_rise, play_fall, play_edge, playing;
    logic aud_elig, aud_low, host_elig, last_rd, rd_active;

    assign play_rise = play & ~play_q;
    assign play_fall = ~play & play_q;
    assign play_edge = play_rise | play_fall;
    assign playing   = play & play_q;

    assign aud_elig  = playing & ~finished_q & ~fifo_full;
    assign aud_low   = (fifo_count < CW'(FIFO_DEPTH / 2));
    assign host_elig = host_req & ~host_ack_q;
    assign last_rd   = (wait_q == WW'(READ_WAIT - 1));

    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Arbitration, access sequencing, pointer update and codec-side handshake.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        addr_d         = addr_q;
        rd_ptr_d       = rd_ptr_q;
        start_d        = start_q;
        end_d          = end_q;
        finished_d     = finished_q;
        discard_d      = discard_q;
        host_rdata_d   = host_rdata_q;
        host_ack_d     = 1'b0;
        sample_out_d   = sample_out_q;
        sample_valid_d = sample_req;
        underrun_d     = underrun_q;
        done_d         = finished_q & fifo_empty;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_flush     = play_edge;
        fifo_din       = SWAP_BYTES ? byte_swap(SRAM_DQ) : SRAM_DQ;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (aud_elig && (aud_low || !host_elig)) begin
                    state_d   = AUD_RD;
                    addr_d    = rd_ptr_q;
                    discard_d = 1'b0;
                end else if (host_elig) begin
                    state_d = HOST_RD;
                    addr_d  = host_addr;
                end
            end
            AUD_RD: begin
                // A play edge mid-read orphans the word; the pins still finish.
                if (play_edge) discard_d = 1'b1;
                if (last_rd) begin
                    state_d = IDLE;
                    wait_d  = '0;
                    if (!(discard_q || play_edge)) begin
                        fifo_push = 1'b1;
                        if (rd_ptr_q == end_q) begin
                            if (loop) rd_ptr_d = start_q;
                            else      finished_d = 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        end
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            HOST_RD: begin
                if (last_rd) begin
                    state_d      = IDLE;
                    wait_d       = '0;
                    host_rdata_d = SRAM_DQ;
                    host_ack_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // New playback session: latch window, restart pointer, clear status.
        if (play_rise) begin
            start_d    = start_addr;
            end_d      = (start_addr > end_addr) ? start_addr : end_addr;
            rd_ptr_d   = start_addr;
            finished_d = 1'b0;
            done_d     = 1'b0;
            underrun_d = 1'b0;
        end

        if (sample_req) begin
            if (fifo_empty) begin
                sample_out_d = '0;
                underrun_d   = 1'b1;
            end else begin
                sample_out_d = fifo_dout;
                fifo_pop     = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wait_q         <= '0;
            addr_q         <= '0;
            rd_ptr_q       <= '0;
            start_q        <= '0;
            end_q          <= '0;
            play_q         <= 1'b0;
            finished_q     <= 1'b0;
            discard_q      <= 1'b0;
            host_rdata_q   <= '0;
            host_ack_q     <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            addr_q         <= addr_d;
            rd_ptr_q       <= rd_ptr_d;
            start_q        <= start_d;
            end_q          <= end_d;
            play_q         <= play;
            finished_q     <= finished_d;
            discard_q      <= discard_d;
            host_rdata_q   <= host_rdata_d;
            host_ack_q     <= host_ack_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
            done_q         <= done_d;
        end
    end

    // Pins are decoded straight from the registered state, so reset idles
    // them without waiting for a clock.
    assign rd_active    = (state_q != IDLE);
    assign SRAM_ADDR    = addr_q;
    assign SRAM_CE_N    = ~rd_active;
    assign SRAM_OE_N    = ~rd_active;
    assign SRAM_UB_N    = ~rd_active;
    assign SRAM_LB_N    = ~rd_active;
    assign SRAM_WE_N    = 1'b1;

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign underrun     = underrun_q;
    assign done         = done_q;
    assign host_rdata   = host_rdata_q;
    assign host_ack     = host_ack_q;

endmodule

// File: tb/tb_audio_sram_streamer.sv
// Directed bench for audio_sram_streamer with a behavioural async SRAM.
module tb_audio_sram_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        play, loop, sample_req, host_req;
    logic [19:0] start_addr, end_addr, host_addr;
    logic [15:0] sample_out, host_rdata, SRAM_DQ;
    logic        sample_valid, underrun, done, host_ack;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    logic [15:0] mem [64];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wrap_cnt = 0;
    logic [19:0] last_a = 20'hFFFFF;

    always #5 clk = ~clk;

    audio_sram_streamer #(.READ_WAIT(2), .FIFO_DEPTH(8), .SWAP_BYTES(1'b1)) dut (
        .clk(clk), .reset(reset), .play(play), .loop(loop),
        .start_addr(start_addr), .end_addr(end_addr), .sample_req(sample_req),
        .sample_out(sample_out), .sample_valid(sample_valid), .underrun(underrun),
        .done(done), .host_req(host_req), .host_addr(host_addr),
        .host_rdata(host_rdata), .host_ack(host_ack), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_DQ(SRAM_DQ)
    );

    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[5:0]] : 16'hDEAD;

    // Count loop wraps: an access to address 0 directly following one to 3.
    always @(posedge clk) begin
        if (!SRAM_CE_N) begin
            if (last_a == 20'd3 && SRAM_ADDR == 20'd0) wrap_cnt <= wrap_cnt + 1;
            last_a <= SRAM_ADDR;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input logic [15:0] exp, input string tag);
        sample_req = 1'b1;
        @(posedge clk); #1 sample_req = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(sample_valid), 1);
        chk(tag, 32'(sample_out), 32'(exp));
    endtask

    initial begin
        logic [8:0]  pat;
        logic [4:0]  ackv;
        logic [15:0] rd;
        logic        found;
        int          base, ack_n;

        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'hF3FF; mem[1] = 16'h0000; mem[2] = 16'hF0FF; mem[3] = 16'h0000;
        mem[5] = 16'hF1FF;

        reset = 1'b1; play = 0; loop = 0; sample_req = 0; host_req = 0;
        start_addr = 0; end_addr = 0; host_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ce",    32'(SRAM_CE_N), 1);
        chk("rst_oe",    32'(SRAM_OE_N), 1);
        chk("rst_we",    32'(SRAM_WE_N), 1);
        chk("rst_ublb",  32'({SRAM_UB_N, SRAM_LB_N}), 3);
        chk("rst_addr",  32'(SRAM_ADDR), 0);
        chk("rst_sout",  32'(sample_out), 0);
        chk("rst_hdata", 32'(host_rdata), 0);
        chk("rst_flags", 32'({sample_valid, host_ack, underrun, done}), 0);
        chk("rst_count", 32'(dut.fifo_count), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Non-loop window 0..3, swapped samples.
        start_addr = 0; end_addr = 3; loop = 0; play = 1;
        cyc(20);
        chk("nl_count", 32'(dut.fifo_count), 4);
        chk("nl_done_early", 32'(done), 0);
        chk("nl_idle", 32'(SRAM_CE_N), 1);
        pop_chk(16'hFFF3, "nl_s0");
        pop_chk(16'h0000, "nl_s1");
        pop_chk(16'hFFF0, "nl_s2");
        pop_chk(16'h0000, "nl_s3");
        cyc(2); @(negedge clk);
        chk("nl_done", 32'(done), 1);
        chk("nl_no_underrun", 32'(underrun), 0);

        // start > end collapses to the single word at start.
        cyc(1); play = 0; cyc(2);
        start_addr = 2; end_addr = 1; play = 1;
        cyc(12);
        chk("sw_count", 32'(dut.fifo_count), 1);
        pop_chk(16'hFFF0, "sw_s0");
        cyc(2); @(negedge clk);
        chk("sw_done", 32'(done), 1);

        // Request right after the play edge hits an empty FIFO.
        cyc(1); play = 0; cyc(2);
        start_addr = 0; end_addr = 3; loop = 0; play = 1;
        cyc(1);
        pop_chk(16'h0000, "ur_data");
        chk("ur_flag", 32'(underrun), 1);
        cyc(15); @(negedge clk);
        chk("ur_sticky", 32'(underrun), 1);
        chk("ur_count", 32'(dut.fifo_count), 4);
        cyc(1); play = 0; cyc(2);
        play = 1; cyc(1); @(negedge clk);
        chk("ur_cleared", 32'(underrun), 0);
        chk("rise_done_clr", 32'(done), 0);

        // Looping window: back-to-back accesses with one idle turnaround.
        cyc(1); play = 0; cyc(2);
        loop = 1; play = 1;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (!SRAM_CE_N) found = 1;
        end
        chk("lp_ce_seen", 32'(found), 1);
        pat = '0;
        pat[0] = SRAM_CE_N;
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            pat[i] = SRAM_CE_N;
        end
        chk("lp_ce_gap", 32'(pat), 32'b100100100);
        base = wrap_cnt;
        cyc(30);
        chk("lp_full", 32'(dut.fifo_count), 8);
        chk("lp_wrapped", 32'(wrap_cnt > base), 1);
        pop_chk(16'hFFF3, "lp_s0");
        pop_chk(16'h0000, "lp_s1");
        pop_chk(16'hFFF0, "lp_s2");
        pop_chk(16'h0000, "lp_s3");
        pop_chk(16'hFFF3, "lp_s4");
        pop_chk(16'h0000, "lp_s5");
        chk("lp_done", 32'(done), 0);

        // Host read with the FIFO full: unblocked latency.
        cyc(30);
        chk("hf_full", 32'(dut.fifo_count), 8);
        host_addr = 5; host_req = 1;
        ackv = '0; rd = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ackv[i] = host_ack;
            if (host_ack) rd = host_rdata;
            if (i == 1) chk("hf_pins", 32'({SRAM_CE_N, SRAM_ADDR}), 32'h00005);
            @(posedge clk); #1;
            if (ackv[i]) host_req = 0;
        end
        chk("hf_ack_time", 32'(ackv), 32'b01000);
        chk("hf_rdata", 32'(rd), 32'hF1FF);

        // Host request while audio is below half full: audio first.
        play = 0; host_req = 0; cyc(2);
        loop = 0; start_addr = 0; end_addr = 5; play = 1;
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (dut.fifo_count == 3 && SRAM_CE_N) found = 1;
        end
        chk("ha_cnt3_seen", 32'(found), 1);
        host_addr = 5; host_req = 1;
        ack_n = 0; rd = '0;
        for (int n = 1; n <= 12 && ack_n == 0; n++) begin
            @(negedge clk);
            if (n == 1) chk("ha_aud_first", 32'({SRAM_CE_N, SRAM_ADDR}), 32'h00003);
            if (n == 3) chk("ha_turnaround", 32'(SRAM_CE_N), 1);
            if (n == 4) chk("ha_host_next", 32'({SRAM_CE_N, SRAM_ADDR}), 32'h00005);
            if (host_ack) begin
                ack_n = n;
                rd = host_rdata;
            end
        end
        chk("ha_ack_time", 32'(ack_n), 6);
        chk("ha_rdata", 32'(rd), 32'hF1FF);
        @(posedge clk); #1 host_req = 0;

        // play dropped mid audio read: pins finish, data discarded.
        play = 0; cyc(2);
        start_addr = 0; end_addr = 3; loop = 0; play = 1;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (!SRAM_CE_N) found = 1;
        end
        chk("pd_rd_seen", 32'(found), 1);
        play = 0;
        @(negedge clk);
        chk("pd_pins_hold", 32'(SRAM_CE_N), 0);
        cyc(4); @(negedge clk);
        chk("pd_count", 32'(dut.fifo_count), 0);
        chk("pd_idle", 32'(SRAM_CE_N), 1);

        // Reset in the middle of a host read.
        cyc(1);
        host_addr = 5; host_req = 1;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (!SRAM_CE_N) found = 1;
        end
        chk("hr_rd_seen", 32'(found), 1);
        reset = 1; #1;
        chk("hr_pins", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        chk("hr_addr", 32'(SRAM_ADDR), 0);
        chk("hr_ack", 32'(host_ack), 0);
        chk("hr_count", 32'(dut.fifo_count), 0);
        host_req = 0;
        @(posedge clk); #1 reset = 0;
        cyc(2); @(negedge clk);
        chk("hr_after_pins", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        chk("hr_after_ack", 32'({host_ack, host_rdata}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
